fc1_engine: RTL and testbench
=============================

Name: fc1_engine

Overview:
- First fully-connected stage, directly downstream of the flatten buffer.
- Reads the 1024-element flattened activation vector as 32 words of 32 lanes through the flatten read port (fcin_addr/fc1_en/fcin_data).
- Per output neuron: 32-lane MAC against a weight memory, then bias add, rounding, saturation and optional ReLU.
- Emits one 16-bit result per neuron on a valid-pulse interface.

Parameters:
- DATA_WIDTH, 16, activation/weight/bias/result width, signed fixed point.
- FRAC, 8, fractional bits (Q7.8 at defaults).
- NUM_OUT, 10, number of output neurons.
- ACC_W, 48, accumulator width.
- RELU, 1, 1 = clamp negative results to 0; 0 = pass through.
- W_ADDR_W, 9, weight address width; must satisfy 2^W_ADDR_W >= NUM_OUT*32.
- B_ADDR_W, 4, bias/neuron-index width; must satisfy 2^B_ADDR_W >= NUM_OUT.

Ports:
- clk  in  1  single clock for all logic and both memories.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a full layer pass when idle.
- fc1_en  out  1  read enable to flatten buffer.
- fcin_addr  out  5  flatten word address k (0..31).
- fcin_data  in  DATA_WIDTH*32  activations; lane i = bits [16i+15:16i].
- w_en  out  1  weight memory read enable.
- w_addr  out  W_ADDR_W  equals j*32+k.
- w_data  in  DATA_WIDTH*32  weights for neuron j, word k; lane-aligned with fcin_data.
- b_addr  out  B_ADDR_W  bias address, equals j.
- b_data  in  DATA_WIDTH  bias for neuron j.
- busy  out  1  high from the cycle after an accepted start until done.
- out_valid  out  1  one-cycle pulse per neuron result.
- out_idx  out  B_ADDR_W  neuron index j of the current result.
- out_data  out  DATA_WIDTH  result value.
- done  out  1  one-cycle pulse after the last neuron.

Behaviour:
- Memory contract: all memories return data exactly 1 cycle after an address is presented with its enable high.
- Reset values: all outputs 0, state IDLE, j=0, k=0, acc=0.
- States:
  - IDLE: start=1 -> RUN with j=0, k=0, acc=0.
  - RUN (32 cycles): fc1_en=w_en=1; fcin_addr=k; w_addr=j*32+k; k increments each cycle. At k=31, b_addr=j and the state moves to DRAIN.
  - DRAIN (3 cycles): fc1_en=w_en=0; the MAC pipeline empties.
  - BIAS (1 cycle): computes the final value.
  - OUT (1 cycle): out_valid=1, out_idx=j. If j=NUM_OUT-1 -> DONE; otherwise j+1, k=0, acc=0 -> RUN.
  - DONE (1 cycle): done=1 -> IDLE.
- Per neuron: 37 cycles. Full pass at NUM_OUT=10: 370 cycles + 1 for DONE.
- MAC pipeline:
  - Data cycle: 32 signed 16x16 products, 32-bit, registered.
  - Next cycle: 32-input adder tree, 37-bit, registered.
  - Next cycle: sign-extend and add into acc (ACC_W).
  - Only beats issued in RUN are accumulated; the pipeline carries a valid bit.
- BIAS arithmetic:
  - r = (acc + (sext(b_data) << FRAC) + 2^(FRAC-1)) >>> FRAC, an arithmetic shift (round half up).
  - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If RELU=1 and r<0, r=0.
  - Registered into out_data.
- out_data holds its value until the next OUT cycle or reset.
- start while busy (not IDLE): ignored; no restart, no output glitch.
- rst mid-operation: returns to IDLE the next edge; all outputs 0; no out_valid or done emitted. rst and start in the same cycle: reset wins.
- fc1_en/w_en are never high outside RUN; fcin_addr and w_addr hold their last value otherwise.
- Accumulator width ACC_W=48 cannot overflow for 1024 terms of 32-bit products.

Test Plan:
1. All activations 0x0100, all weights 0x0001, bias 0, RELU=1 -> 10 out_valid pulses, out_idx 0..9, each out_data=0x0400; done 371 cycles after start.
2. Activations 0x0100, weights 0xFFFF, bias 0 -> RELU=0: out_data=0xFC00; RELU=1: out_data=0x0000.
3. Activations 0x7FFF, weights 0x7FFF -> out_data=0x7FFF (saturated); weights 0x8000 with RELU=0 -> out_data=0x8000.
4. Rounding and bias: only lane 0 of word 0 nonzero, activation 0x0001, weight 0x0080, bias 0x0180 -> out_data=0x0181 (0.5 LSB rounds up).
5. Neuron addressing: weight word j*32+k filled with 0x0100*(j+1) in lane 0 only, activation lane 0 = 0x0100 in every word -> neuron j outputs 32*(j+1) in Q8.8, i.e. 0x2000*(j+1) saturated, so j=0..2 give 0x2000, 0x4000, 0x6000 and j>=3 give 0x7FFF.
6. Control corners: pulse start again at cycle 50 -> no effect, the pass completes normally. Assert rst at cycle 100 -> busy=0 and outputs 0 next cycle, no done pulse. A fresh start after reset -> a correct full pass.

Source files
------------

// File: rtl/fc1_engine_if.sv
// Bus between fc1_engine and its environment: control handshake, flatten/weight/bias
// read ports and the per-neuron result stream. Parameters must match the engine's.
interface fc1_engine_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned W_ADDR_W   = 9,
   parameter int unsigned B_ADDR_W   = 4
);
   logic                       start;
   logic                       busy;
   logic                       done;
   logic                       fc1_en;
   logic [4:0]                 fcin_addr;
   logic [DATA_WIDTH*32-1:0]   fcin_data;
   logic                       w_en;
   logic [W_ADDR_W-1:0]        w_addr;
   logic [DATA_WIDTH*32-1:0]   w_data;
   logic [B_ADDR_W-1:0]        b_addr;
   logic [DATA_WIDTH-1:0]      b_data;
   logic                       out_valid;
   logic [B_ADDR_W-1:0]        out_idx;
   logic [DATA_WIDTH-1:0]      out_data;

   modport master (
      input  start, fcin_data, w_data, b_data,
      output busy, done, fc1_en, fcin_addr, w_en, w_addr, b_addr, out_valid, out_idx, out_data
   );

   modport slave (
      output start, fcin_data, w_data, b_data,
      input  busy, done, fc1_en, fcin_addr, w_en, w_addr, b_addr, out_valid, out_idx, out_data
   );
endinterface

// File: rtl/fc1_engine.sv
// First fully-connected layer: per neuron, 32 beats of 32-lane MAC against the weight memory,
// then bias add, round-half-up, saturate and optional ReLU; one result pulse per neuron.
module fc1_engine #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC       = 8,
   parameter int unsigned NUM_OUT    = 10,
   parameter int unsigned ACC_W      = 48,
   parameter int unsigned RELU       = 1,
   parameter int unsigned W_ADDR_W   = 9,
   parameter int unsigned B_ADDR_W   = 4
) (
   input logic           clk,
   input logic           rst,
   fc1_engine_if.master  bus
);

   localparam int unsigned LANES  = 32;
   localparam int unsigned PROD_W = 2 * DATA_WIDTH;
   localparam int unsigned SUM_W  = PROD_W + 5;

   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (FRAC - 1);

   typedef enum logic [2:0] {StIdle, StRun, StDrain, StBias, StOut, StDone} state_e;

   state_e                state_q;
   logic [B_ADDR_W-1:0]   j_q;
   logic [4:0]            k_q;
   logic [1:0]            drain_q;

   // MAC pipeline: data-valid, product stage, adder-tree stage, accumulator
   logic                       dv_q, pv_q, sv_q;
   logic signed [PROD_W-1:0]   prod_q [LANES];
   logic signed [SUM_W-1:0]    sum_q;
   logic signed [SUM_W-1:0]    tree;
   logic signed [ACC_W-1:0]    acc_q;

   logic signed [DATA_WIDTH-1:0] act_lane [LANES];
   logic signed [DATA_WIDTH-1:0] w_lane   [LANES];

   logic signed [DATA_WIDTH-1:0] b_s;
   logic signed [ACC_W-1:0]      rnd_sum;
   logic signed [ACC_W-1:0]      shifted;
   logic [DATA_WIDTH-1:0]        result;

   function automatic logic [W_ADDR_W-1:0] waddr(input logic [B_ADDR_W-1:0] j,
                                                 input logic [4:0] k);
      return W_ADDR_W'({j, k});
   endfunction

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         act_lane[i] = bus.fcin_data[DATA_WIDTH*i +: DATA_WIDTH];
         w_lane[i]   = bus.w_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
   end

   always_comb begin
      tree = '0;
      for (int i = 0; i < LANES; i++) begin
         tree = tree + SUM_W'(prod_q[i]);
      end
   end

   always_comb begin
      b_s     = bus.b_data;
      rnd_sum = acc_q + (ACC_W'(b_s) <<< FRAC) + HALF;
      shifted = rnd_sum >>> FRAC;
      if (shifted > SAT_MAX) begin
         result = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         result = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         result = shifted[DATA_WIDTH-1:0];
      end
      if (RELU != 0 && shifted < 0) begin
         result = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dv_q  <= 1'b0;
         pv_q  <= 1'b0;
         sv_q  <= 1'b0;
         sum_q <= '0;
         acc_q <= '0;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         // Memory data arrives the cycle after the enable, so the valid bit trails fc1_en.
         dv_q <= bus.fc1_en;
         pv_q <= dv_q;
         sv_q <= pv_q;
         if (dv_q) begin
            for (int i = 0; i < LANES; i++) begin
               prod_q[i] <= PROD_W'(act_lane[i]) * PROD_W'(w_lane[i]);
            end
         end
         if (pv_q) begin
            sum_q <= tree;
         end
         if (state_q == StIdle || state_q == StOut) begin
            acc_q <= '0;
         end else if (sv_q) begin
            acc_q <= acc_q + ACC_W'(sum_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         j_q           <= '0;
         k_q           <= '0;
         drain_q       <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.fc1_en    <= 1'b0;
         bus.w_en      <= 1'b0;
         bus.fcin_addr <= '0;
         bus.w_addr    <= '0;
         bus.b_addr    <= '0;
         bus.out_valid <= 1'b0;
         bus.out_idx   <= '0;
         bus.out_data  <= '0;
      end else begin
         bus.out_valid <= 1'b0;
         bus.done      <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  state_q       <= StRun;
                  j_q           <= '0;
                  k_q           <= '0;
                  bus.busy      <= 1'b1;
                  bus.fc1_en    <= 1'b1;
                  bus.w_en      <= 1'b1;
                  bus.fcin_addr <= '0;
                  bus.w_addr    <= waddr('0, '0);
                  bus.b_addr    <= '0;
               end
            end
            StRun: begin
               if (k_q == 5'd31) begin
                  state_q    <= StDrain;
                  drain_q    <= '0;
                  bus.fc1_en <= 1'b0;
                  bus.w_en   <= 1'b0;
               end else begin
                  k_q           <= k_q + 5'd1;
                  bus.fcin_addr <= k_q + 5'd1;
                  bus.w_addr    <= waddr(j_q, k_q + 5'd1);
               end
            end
            StDrain: begin
               if (drain_q == 2'd2) begin
                  state_q <= StBias;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            StBias: begin
               state_q       <= StOut;
               bus.out_valid <= 1'b1;
               bus.out_idx   <= j_q;
               bus.out_data  <= result;
            end
            StOut: begin
               if (j_q == B_ADDR_W'(NUM_OUT - 1)) begin
                  state_q  <= StDone;
                  bus.done <= 1'b1;
                  bus.busy <= 1'b0;
               end else begin
                  state_q       <= StRun;
                  j_q           <= j_q + 1'b1;
                  k_q           <= '0;
                  bus.fc1_en    <= 1'b1;
                  bus.w_en      <= 1'b1;
                  bus.fcin_addr <= '0;
                  bus.w_addr    <= waddr(j_q + 1'b1, '0);
                  bus.b_addr    <= j_q + 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc1_engine.sv
// Scoreboard bench for fc1_engine: two instances (RELU=1 and RELU=0) share the same memories;
// expected results come from a plain-arithmetic dot-product model.
module tb_fc1_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;

   always #5 clk = ~clk;

   fc1_engine_if #(.DATA_WIDTH(16), .W_ADDR_W(9), .B_ADDR_W(4)) bus_r ();
   fc1_engine_if #(.DATA_WIDTH(16), .W_ADDR_W(9), .B_ADDR_W(4)) bus_p ();

   assign bus_r.start = start;
   assign bus_p.start = start;

   fc1_engine #(.RELU(1)) dut_r (.clk(clk), .rst(rst), .bus(bus_r));
   fc1_engine #(.RELU(0)) dut_p (.clk(clk), .rst(rst), .bus(bus_p));

   logic [511:0] act_mem [32];
   logic [511:0] w_mem   [512];
   logic [15:0]  b_mem   [16];

   always @(posedge clk) begin
      if (bus_r.fc1_en) bus_r.fcin_data <= act_mem[bus_r.fcin_addr];
      if (bus_r.w_en)   bus_r.w_data    <= w_mem[bus_r.w_addr];
      bus_r.b_data <= b_mem[bus_r.b_addr];
      if (bus_p.fc1_en) bus_p.fcin_data <= act_mem[bus_p.fcin_addr];
      if (bus_p.w_en)   bus_p.w_data    <= w_mem[bus_p.w_addr];
      bus_p.b_data <= b_mem[bus_p.b_addr];
   end

   logic [19:0] q_r [$];
   logic [19:0] q_p [$];
   int n_chk = 0;
   int n_pass = 0;
   int n_done_exp = 0;
   int n_done_r = 0;
   int n_done_p = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   function automatic logic [15:0] model(input int j, input bit relu);
      longint acc, r;
      logic signed [15:0] a, w, b;
      acc = 0;
      for (int k = 0; k < 32; k++) begin
         for (int i = 0; i < 32; i++) begin
            a = act_mem[k][16*i +: 16];
            w = w_mem[j*32 + k][16*i +: 16];
            acc += longint'(a) * longint'(w);
         end
      end
      b = b_mem[j];
      r = (acc + longint'(b) * 256 + 128) >>> 8;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return r[15:0];
   endfunction

   // Monitor: pops the scoreboard whenever an instance presents a result
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_r.out_valid) begin
            check("relu1 result expected", 64'(q_r.size() != 0), 64'd1);
            if (q_r.size() != 0) check("relu1 neuron result", {bus_r.out_idx, bus_r.out_data},
                                       q_r.pop_front());
         end
         if (bus_p.out_valid) begin
            check("relu0 result expected", 64'(q_p.size() != 0), 64'd1);
            if (q_p.size() != 0) check("relu0 neuron result", {bus_p.out_idx, bus_p.out_data},
                                       q_p.pop_front());
         end
         if (bus_r.done) n_done_r++;
         if (bus_p.done) n_done_p++;
      end
   end

   function automatic logic [63:0] outs(input logic busy, out_valid, done, fc1_en, w_en,
                                        input logic [4:0] fa, input logic [8:0] wa,
                                        input logic [3:0] ba, oi, input logic [15:0] od);
      return 64'({busy, out_valid, done, fc1_en, w_en, fa, wa, ba, oi, od});
   endfunction

   task automatic check_zero(input string tag);
      check({tag, " relu1 outputs zero"}, outs(bus_r.busy, bus_r.out_valid, bus_r.done,
            bus_r.fc1_en, bus_r.w_en, bus_r.fcin_addr, bus_r.w_addr, bus_r.b_addr,
            bus_r.out_idx, bus_r.out_data), 64'd0);
      check({tag, " relu0 outputs zero"}, outs(bus_p.busy, bus_p.out_valid, bus_p.done,
            bus_p.fc1_en, bus_p.w_en, bus_p.fcin_addr, bus_p.w_addr, bus_p.b_addr,
            bus_p.out_idx, bus_p.out_data), 64'd0);
   endtask

   task automatic fill_uniform(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
      for (int k = 0; k < 32; k++) act_mem[k] = {32{a}};
      for (int n = 0; n < 512; n++) w_mem[n] = {32{w}};
      for (int n = 0; n < 16; n++) b_mem[n] = b;
   endtask

   task automatic fill_random();
      for (int k = 0; k < 32; k++)
         for (int i = 0; i < 32; i++) act_mem[k][16*i +: 16] = 16'($urandom_range(0, 127)) - 16'd64;
      for (int n = 0; n < 512; n++)
         for (int i = 0; i < 32; i++) w_mem[n][16*i +: 16] = 16'($urandom_range(0, 255)) - 16'd128;
      for (int n = 0; n < 16; n++) b_mem[n] = 16'($urandom_range(0, 4095)) - 16'd2048;
   endtask

   task automatic push_expected();
      for (int j = 0; j < 10; j++) begin
         q_r.push_back({4'(j), model(j, 1'b1)});
         q_p.push_back({4'(j), model(j, 1'b0)});
      end
   endtask

   // Called at a negedge; start is high for one cycle, optional extra start at restart_at
   task automatic run_pass(input int restart_at);
      int cyc;
      push_expected();
      start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start = (cyc == restart_at);
         if (cyc == 200) check("busy mid-pass", 64'(bus_r.busy), 64'd1);
      end while (!bus_r.done && cyc < 1000);
      start = 1'b0;
      check("done latency", 64'(cyc), 64'd371);
      check("relu0 done aligned", 64'(bus_p.done), 64'd1);
      n_done_exp++;
      check("relu1 results outstanding", 64'(q_r.size()), 64'd0);
      check("relu0 results outstanding", 64'(q_p.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic abort_pass(input int reset_at);
      int cyc;
      push_expected();
      start = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
      end while (cyc < reset_at);
      rst = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      check_zero("after mid-pass reset");
      q_r.delete();
      q_p.delete();
      repeat (450) @(negedge clk);
      check("busy stays low after reset", 64'(bus_r.busy), 64'd0);
   endtask

   initial begin
      fill_uniform(16'h0000, 16'h0000, 16'h0000);
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      fill_uniform(16'h0100, 16'h0001, 16'h0000);
      run_pass(0);
      fill_uniform(16'h0100, 16'hFFFF, 16'h0000);
      run_pass(0);
      fill_uniform(16'h7FFF, 16'h7FFF, 16'h0000);
      run_pass(0);
      fill_uniform(16'h7FFF, 16'h8000, 16'h0000);
      run_pass(0);

      fill_uniform(16'h0000, 16'h0000, 16'h0180);
      act_mem[0][15:0] = 16'h0001;
      for (int j = 0; j < 10; j++) w_mem[j*32][15:0] = 16'h0080;
      run_pass(0);

      fill_uniform(16'h0000, 16'h0000, 16'h0000);
      for (int k = 0; k < 32; k++) act_mem[k][15:0] = 16'h0100;
      for (int j = 0; j < 10; j++)
         for (int k = 0; k < 32; k++) w_mem[j*32 + k][15:0] = 16'(16'h0100 * (j + 1));
      run_pass(0);

      for (int t = 0; t < 2; t++) begin
         fill_random();
         run_pass(0);
      end

      fill_random();
      run_pass(50);
      abort_pass(100);
      fill_random();
      run_pass(0);

      check("relu1 done pulse count", 64'(n_done_r), 64'(n_done_exp));
      check("relu0 done pulse count", 64'(n_done_p), 64'(n_done_exp));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
